// File: rtl/axis_frame_source_if.sv
// ============================================================================
// axis_frame_source_if : AXI-Stream beat bus (valid/ready/data/last)
// Rev 1.0
// ============================================================================
`default_nettype none

interface axis_frame_source_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

`default_nettype wire

// File: rtl/axis_frame_source.sv
// ============================================================================
// axis_frame_source : AXI-Stream master emitting one test-pattern image frame
// Rev 1.0
// ============================================================================
`default_nettype none

module axis_frame_source #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int LAST_MODE  = 0
) (
  input  wire logic       axi_clk,
  input  wire logic       axi_reset,
  input  wire logic       start,
  input  wire logic [1:0] pattern_sel,
  input  wire logic [7:0] seed,
  axis_frame_source_if.master m_axis,
  output logic            busy,
  output logic            done
);

  localparam int PIX_PER_BEAT = DATA_WIDTH / 8;
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam logic [XW-1:0] C_X_LAST = XW'(IMG_W - PIX_PER_BEAT);
  localparam logic [YW-1:0] C_Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] C_X_STEP = XW'(PIX_PER_BEAT);
  localparam logic [7:0]    C_I_STEP = 8'(PIX_PER_BEAT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [7:0]      idx_q, idx_d;
  logic [1:0]      pat_q, pat_d;
  logic [7:0]      seed_q, seed_d;

  logic            w_line_end;
  logic            w_frame_end;
  logic            w_valid;
  logic            w_ybit;
  logic [DATA_WIDTH-1:0] w_data;

  function automatic logic [7:0] pix_f(input logic [1:0] pat, input logic [7:0] sd,
                                       input logic [7:0] idx, input logic [7:0] xk,
                                       input logic ybit);
    case (pat)
      2'd0:    pix_f = idx;
      2'd1:    pix_f = sd;
      2'd2:    pix_f = xk;
      default: pix_f = (xk[3] ^ ybit) ? ~sd : sd;
    endcase
  endfunction

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      seed_q  <= seed_d;
    end
  end

  assign w_line_end  = (x_q == C_X_LAST);
  assign w_frame_end = w_line_end && (y_q == C_Y_LAST);
  assign w_valid     = (state_q == ST_STREAM);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    seed_d  = seed_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d   = pattern_sel;
          seed_d  = seed;
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (m_axis.ready) begin
          // Running index replaces y*IMG_W+x; it wraps naturally at 256.
          idx_d = idx_q + C_I_STEP;
          if (w_line_end) begin
            x_d = '0;
            if (w_frame_end) state_d = ST_DONE;
            else             y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + C_X_STEP;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_ybit = ((8'(y_q) >> 3) & 8'd1) != 8'd0;

  always_comb begin
    w_data = '0;
    if (w_valid) begin
      for (int k = 0; k < PIX_PER_BEAT; k++) begin
        w_data[8*k +: 8] = pix_f(pat_q, seed_q, idx_q + 8'(k), 8'(x_q) + 8'(k), w_ybit);
      end
    end
  end

  assign m_axis.valid = w_valid;
  assign m_axis.data  = w_data;
  assign m_axis.last  = w_valid && w_line_end && ((LAST_MODE != 0) || (y_q == C_Y_LAST));
  assign busy         = w_valid;
  assign done         = (state_q == ST_DONE);

endmodule

`default_nettype wire
